mode_stopwatch2: RTL and testbench

Functional stopwatch mode for the 16x2 character-LCD watch: BCD time counter (MM:SS.CC) advanced by the 100 Hz enable, run/stop/clear control, and a circular lap buffer. Renders its screen as an ASCII character stream addressed by the LCD driver's character index. It is the parametrised successor of the static stopwatch screen, with real counting, lap capture and lap browsing.

---
 rtl/mode_stopwatch2_if.sv | 24 ++
 rtl/mode_stopwatch2.sv | 195 +++++++++++++++++++
 tb/tb_mode_stopwatch2.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mode_stopwatch2_if.sv
// Control/display bundle between the LCD watch core and the stopwatch mode.
// The master drives pulses and the character index; the slave returns the character and status.
interface mode_stopwatch2_if #(
   parameter int unsigned IDX_W = 5
);
   logic             en_100hz;
   logic             btn_start;
   logic             btn_lap;
   logic             btn_clear;
   logic [IDX_W-1:0] index;
   logic [7:0]       out;
   logic             running;
   logic [3:0]       lap_count;

   modport master (
      output en_100hz, btn_start, btn_lap, btn_clear, index,
      input  out, running, lap_count
   );

   modport slave (
      input  en_100hz, btn_start, btn_lap, btn_clear, index,
      output out, running, lap_count
   );
endinterface

// File: rtl/mode_stopwatch2.sv
// Stopwatch mode: BCD MM:SS.CC counter, run/stop/clear control, circular lap buffer,
// and a registered ASCII renderer addressed by the LCD character index.
module mode_stopwatch2 #(
   parameter int unsigned COLS      = 16,
   parameter int unsigned LINES     = 2,
   parameter int unsigned LAP_DEPTH = 4,
   parameter int unsigned MAX_MIN   = 99,
   parameter int unsigned IDX_W     = 5
) (
   input logic             clk,
   input logic             rst,
   mode_stopwatch2_if.slave bus
);

   localparam int unsigned    PtrW      = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam logic [7:0]     MaxMinBcd = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(LAP_DEPTH - 1);
   localparam logic [3:0]     FullCount = 4'(LAP_DEPTH);

   typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

   // Time packing: {m_hi, m_lo, s_hi, s_lo, c_hi, c_lo}, one BCD nibble each.
   state_e           state_q, state_d;
   logic [23:0]      time_q, time_d;
   logic [23:0]      lap_q [LAP_DEPTH];
   logic [23:0]      lap_d [LAP_DEPTH];
   logic [3:0]       lap_count_q, lap_count_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  view_ptr_q, view_ptr_d;
   logic [7:0]       out_q, out_d;

   logic             at_max;
   int unsigned      age;
   logic             at_oldest;
   logic [3:0]       lap_num;
   logic [IDX_W-1:0] index_w;
   int unsigned      idx, line, col;

   function automatic logic [23:0] bcd_inc(logic [23:0] t);
      logic [23:0] r;
      r = t;
      if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
      else begin
         r[3:0] = 4'd0;
         if (t[7:4] != 4'd9) r[7:4] = t[7:4] + 4'd1;
         else begin
            r[7:4] = 4'd0;
            if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
            else begin
               r[11:8] = 4'd0;
               if (t[15:12] != 4'd5) r[15:12] = t[15:12] + 4'd1;
               else begin
                  r[15:12] = 4'd0;
                  if (t[19:16] != 4'd9) r[19:16] = t[19:16] + 4'd1;
                  else begin
                     r[19:16] = 4'd0;
                     r[23:20] = t[23:20] + 4'd1;
                  end
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] state_char(state_e s, logic [1:0] pos);
      logic [31:0] str;
      unique case (s)
         StRun:   str = "RUN ";
         StStop:  str = "STOP";
         default: str = "IDLE";
      endcase
      unique case (pos)
         2'd0: return str[31:24];
         2'd1: return str[23:16];
         2'd2: return str[15:8];
         2'd3: return str[7:0];
      endcase
   endfunction

   function automatic logic [7:0] time_char(logic [23:0] t, logic [2:0] pos, logic dash);
      logic [3:0] d;
      case (pos)
         3'd0:    d = t[23:20];
         3'd1:    d = t[19:16];
         3'd3:    d = t[15:12];
         3'd4:    d = t[11:8];
         3'd6:    d = t[7:4];
         3'd7:    d = t[3:0];
         default: d = 4'd0;
      endcase
      if (pos == 3'd2)      return 8'h3A;
      else if (pos == 3'd5) return 8'h2E;
      else if (dash)        return 8'h2D;
      else                  return 8'h30 + {4'h0, d};
   endfunction

   assign at_max = (time_q[23:16] == MaxMinBcd) && (time_q[15:0] == 16'h5999);

   // Age 0 is the newest entry; the displayed lap number counts down from lap_count.
   assign age       = (32'(wr_ptr_q) + 2 * LAP_DEPTH - 1 - 32'(view_ptr_q)) % LAP_DEPTH;
   assign at_oldest = (age + 1 == 32'(lap_count_q));
   assign lap_num   = lap_count_q - 4'(age);

   always_comb begin
      state_d     = state_q;
      time_d      = time_q;
      lap_d       = lap_q;
      lap_count_d = lap_count_q;
      wr_ptr_d    = wr_ptr_q;
      view_ptr_d  = view_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (bus.btn_start) state_d = StRun;
         end
         StRun: begin
            if (bus.en_100hz) begin
               if (at_max) state_d = StStop;
               else        time_d  = bcd_inc(time_q);
            end
            if (bus.btn_start) begin
               state_d = StStop;
            end else if (bus.btn_lap) begin
               lap_d[wr_ptr_q] = time_q;
               wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
               view_ptr_d      = wr_ptr_q;
               if (lap_count_q != FullCount) lap_count_d = lap_count_q + 4'd1;
            end
         end
         StStop: begin
            if (bus.btn_start) begin
               state_d = StRun;
            end else if (bus.btn_clear) begin
               state_d     = StIdle;
               time_d      = '0;
               lap_count_d = '0;
               wr_ptr_d    = '0;
               view_ptr_d  = '0;
            end else if (bus.btn_lap && (lap_count_q != 4'd0)) begin
               if (at_oldest) view_ptr_d = (wr_ptr_q == '0) ? LastPtr : wr_ptr_q - 1'b1;
               else           view_ptr_d = (view_ptr_q == '0) ? LastPtr : view_ptr_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign index_w = bus.index;
   assign idx     = 32'(index_w);
   assign line    = idx / COLS;
   assign col     = idx % COLS;

   always_comb begin
      out_d = 8'h20;
      if (idx < COLS * LINES) begin
         if (line == 0) begin
            if (col < 4)                    out_d = state_char(state_q, 2'(col));
            else if (col >= 5 && col <= 12) out_d = time_char(time_q, 3'(col - 5), 1'b0);
         end else if (line == 1) begin
            if (col == 0) begin
               out_d = 8'h4C;
            end else if (col == 1) begin
               out_d = (lap_count_q == 4'd0) ? 8'h2D : 8'h30 + {4'h0, lap_num};
            end else if (col >= 5 && col <= 12) begin
               out_d = time_char(lap_q[view_ptr_q], 3'(col - 5), lap_count_q == 4'd0);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         time_q      <= '0;
         for (int i = 0; i < LAP_DEPTH; i++) lap_q[i] <= '0;
         lap_count_q <= '0;
         wr_ptr_q    <= '0;
         view_ptr_q  <= '0;
         out_q       <= 8'h20;
      end else begin
         state_q     <= state_d;
         time_q      <= time_d;
         lap_q       <= lap_d;
         lap_count_q <= lap_count_d;
         wr_ptr_q    <= wr_ptr_d;
         view_ptr_q  <= view_ptr_d;
         out_q       <= out_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.running   = (state_q == StRun);
   assign bus.lap_count = lap_count_q;

endmodule

// File: tb/tb_mode_stopwatch2.sv
// Directed bench for mode_stopwatch2: a vector table of button/tick actions with expected
// screens, plus hand sequences for minute saturation and asynchronous reset.
module tb_mode_stopwatch2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mode_stopwatch2_if #(.IDX_W(5)) b0 ();
   mode_stopwatch2_if #(.IDX_W(5)) b1 ();

   mode_stopwatch2 u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0.slave)
   );

   mode_stopwatch2 #(.MAX_MIN(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   typedef struct {
      string name;
      int    ticks;
      bit    st, lp, cl, en;
      string l0, l1;
      bit    run;
      int    cnt;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   passes = 0;
   bit   sel    = 1'b0;

   function automatic void add(string nm, int t, bit s, bit l, bit c, bit e,
                               string l0, string l1, bit r, int n);
      vec_t v;
      v.name = nm; v.ticks = t; v.st = s; v.lp = l; v.cl = c; v.en = e;
      v.l0 = l0; v.l1 = l1; v.run = r; v.cnt = n;
      vecs.push_back(v);
   endfunction

   task automatic drive(bit s, bit l, bit c, bit e);
      b0.btn_start = s; b0.btn_lap = l; b0.btn_clear = c; b0.en_100hz = e;
      b1.btn_start = s; b1.btn_lap = l; b1.btn_clear = c; b1.en_100hz = e;
   endtask

   task automatic pulse(bit s, bit l, bit c, bit e);
      drive(s, l, c, e);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ticks(int n);
      if (n > 0) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1);
         repeat (n) @(negedge clk);
         drive(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic read_line(int ln, output string s);
      logic [7:0] ch;
      s = "";
      for (int c = 0; c < 16; c++) begin
         b0.index = 5'(ln * 16 + c);
         b1.index = 5'(ln * 16 + c);
         @(negedge clk);
         ch = sel ? b1.out : b0.out;
         s = $sformatf("%s%c", s, ch);
      end
   endtask

   task automatic chk_str(string nm, string got, string exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got \"%s\" expected \"%s\"", nm, got, exp);
   endtask

   task automatic chk_int(string nm, int got, int exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
   endtask

   task automatic check_state(string nm, string l0, string l1, bit run, int cnt);
      string s;
      chk_int({nm, ".running"}, int'(sel ? b1.running : b0.running), int'(run));
      chk_int({nm, ".lap_count"}, int'(sel ? b1.lap_count : b0.lap_count), cnt);
      read_line(0, s);
      chk_str({nm, ".line0"}, s, l0);
      read_line(1, s);
      chk_str({nm, ".line1"}, s, l1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      b0.index = '0;
      b1.index = '0;

      //   name          ticks st lp cl en  line0                 line1                run cnt
      add("reset",        0,   0, 0, 0, 0, "IDLE 00:00.00   ", "L-   --:--.--   ", 0, 0);
      add("idle_ignore",  5,   0, 1, 1, 0, "IDLE 00:00.00   ", "L-   --:--.--   ", 0, 0);
      add("start",        0,   1, 0, 0, 0, "RUN  00:00.00   ", "L-   --:--.--   ", 1, 0);
      add("run6123",      6123, 1, 0, 0, 0, "STOP 01:01.23   ", "L-   --:--.--   ", 0, 0);
      add("stop_frozen",  50,  0, 0, 0, 0, "STOP 01:01.23   ", "L-   --:--.--   ", 0, 0);
      add("clear",        0,   0, 0, 1, 0, "IDLE 00:00.00   ", "L-   --:--.--   ", 0, 0);
      add("start2",       0,   1, 0, 0, 0, "RUN  00:00.00   ", "L-   --:--.--   ", 1, 0);
      add("lap_050",      50,  0, 1, 0, 0, "RUN  00:00.50   ", "L1   00:00.50   ", 1, 1);
      add("lap_100",      50,  0, 1, 0, 0, "RUN  00:01.00   ", "L2   00:01.00   ", 1, 2);
      add("stop2",        0,   1, 0, 0, 0, "STOP 00:01.00   ", "L2   00:01.00   ", 0, 2);
      add("browse_l1",    0,   0, 1, 0, 0, "STOP 00:01.00   ", "L1   00:00.50   ", 0, 2);
      add("browse_wrap",  0,   0, 1, 0, 0, "STOP 00:01.00   ", "L2   00:01.00   ", 0, 2);
      add("clear2",       0,   0, 0, 1, 0, "IDLE 00:00.00   ", "L-   --:--.--   ", 0, 0);
      add("start3",       0,   1, 0, 0, 0, "RUN  00:00.00   ", "L-   --:--.--   ", 1, 0);
      add("lap1s",        100, 0, 1, 0, 0, "RUN  00:01.00   ", "L1   00:01.00   ", 1, 1);
      add("lap2s",        100, 0, 1, 0, 0, "RUN  00:02.00   ", "L2   00:02.00   ", 1, 2);
      add("lap3s",        100, 0, 1, 0, 0, "RUN  00:03.00   ", "L3   00:03.00   ", 1, 3);
      add("lap4s",        100, 0, 1, 0, 0, "RUN  00:04.00   ", "L4   00:04.00   ", 1, 4);
      add("lap5s_wrap",   100, 0, 1, 0, 0, "RUN  00:05.00   ", "L4   00:05.00   ", 1, 4);
      add("lap6s_wrap",   100, 0, 1, 0, 0, "RUN  00:06.00   ", "L4   00:06.00   ", 1, 4);
      add("stop3",        0,   1, 0, 0, 0, "STOP 00:06.00   ", "L4   00:06.00   ", 0, 4);
      add("br_5s",        0,   0, 1, 0, 0, "STOP 00:06.00   ", "L3   00:05.00   ", 0, 4);
      add("br_4s",        0,   0, 1, 0, 0, "STOP 00:06.00   ", "L2   00:04.00   ", 0, 4);
      add("br_3s",        0,   0, 1, 0, 0, "STOP 00:06.00   ", "L1   00:03.00   ", 0, 4);
      add("br_wrap6s",    0,   0, 1, 0, 0, "STOP 00:06.00   ", "L4   00:06.00   ", 0, 4);
      add("start_clear",  0,   1, 0, 1, 0, "RUN  00:06.00   ", "L4   00:06.00   ", 1, 4);
      add("stop4",        0,   1, 0, 0, 0, "STOP 00:06.00   ", "L4   00:06.00   ", 0, 4);
      add("clear3",       0,   0, 0, 1, 0, "IDLE 00:00.00   ", "L-   --:--.--   ", 0, 0);
      add("start4",       0,   1, 0, 0, 0, "RUN  00:00.00   ", "L-   --:--.--   ", 1, 0);
      add("lap_with_tick", 99, 0, 1, 0, 1, "RUN  00:01.00   ", "L1   00:00.99   ", 1, 1);
      add("start_over_lap", 0, 1, 1, 0, 0, "STOP 00:01.00   ", "L1   00:00.99   ", 0, 1);

      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         ticks(vecs[i].ticks);
         if (vecs[i].st || vecs[i].lp || vecs[i].cl || vecs[i].en)
            pulse(vecs[i].st, vecs[i].lp, vecs[i].cl, vecs[i].en);
         check_state(vecs[i].name, vecs[i].l0, vecs[i].l1, vecs[i].run, vecs[i].cnt);
      end

      // Minute saturation on the MAX_MIN=1 instance.
      sel = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(11999);
      check_state("max_edge", "RUN  01:59.99   ", "L-   --:--.--   ", 1, 0);
      ticks(1);
      check_state("max_hold", "STOP 01:59.99   ", "L-   --:--.--   ", 0, 0);
      ticks(5);
      check_state("max_frozen", "STOP 01:59.99   ", "L-   --:--.--   ", 0, 0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      check_state("max_clear", "IDLE 00:00.00   ", "L-   --:--.--   ", 0, 0);

      // Asynchronous reset in the middle of a run, with a lap stored.
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(10);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk_int("pre_rst.running", int'(b1.running), 1);
      chk_int("pre_rst.lap_count", int'(b1.lap_count), 1);
      rst = 1'b0;
      #1;
      chk_int("async_rst.running", int'(b1.running), 0);
      chk_int("async_rst.lap_count", int'(b1.lap_count), 0);
      chk_int("async_rst.out", int'(b1.out), 32'h20);
      @(negedge clk);
      rst = 1'b1;
      check_state("after_rst", "IDLE 00:00.00   ", "L-   --:--.--   ", 0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
